hazard_stall_unit: RTL and testbench
====================================

// Module: hazard_stall_unit
// PURPOSE
//  Generates the stall consumed by Control_Unit, plus PC / IF-ID write enables and pipeline flushes, for the 5-stage RV64 core.
//  Tracks in-flight loads in EX (and MEM when MEM_FWD=0) and detects load-use hazards against the instruction in ID.
//  Sequences branch-taken flushes with a small FSM. Counts stall and flush cycles for performance debug.
// PARAMETERS
//  MEM_FWD       1   1: MEM/WB forwarding exists, check EX-stage loads only; 0: also check MEM-stage loads
//  FLUSH_CYCLES  1   cycles of IF/ID+ID/EX flush per taken branch (1..3)
//  CNT_W         16  width of the saturating performance counters
// PORTS
//  clk          in   1      core clock, all state on rising edge
//  rst_n        in   1      asynchronous active-low reset
//  id_valid     in   1      ID stage holds a real instruction
//  id_opcode    in   7      opcode of the ID instruction
//  id_rs1       in   5      rs1 field of the ID instruction
//  id_rs2       in   5      rs2 field of the ID instruction
//  id_rd        in   5      rd field of the ID instruction
//  ex_br_taken  in   1      beq in EX resolved taken (one-cycle pulse)
//  cnt_clr      in   1      synchronous clear of both counters
//  stall        out  1      to Control_Unit.stall: zeroes ID control (bubble)
//  pc_write     out  1      PC update enable
//  ifid_write   out  1      IF/ID register write enable
//  ifid_flush   out  1      IF/ID register clear
//  idex_flush   out  1      ID/EX register clear
//  stall_cnt    out  CNT_W  cycles with stall=1 (saturating)
//  flush_cnt    out  CNT_W  cycles with idex_flush=1 (saturating)
// BEHAVIOUR
//  - Reset (rst_n=0, async): state=RUN, flush counter=0, ex_ld/mem_ld=0, ex_rd/mem_rd=0, counters=0.
//    While rst_n=0 all outputs are forced low: stall, pc_write, ifid_write, ifid_flush, idex_flush=0.
//  - Source use by opcode:
//    0110011, 0100011, 1100011 use rs1+rs2; 0000011, 0010011 use rs1 only; all others use none.
//  - Load tracking, every edge:
//    mem_ld<=ex_ld, mem_rd<=ex_rd; if stall|idex_flush then ex_ld<=0;
//    else ex_ld<=id_valid&(id_opcode==0000011), ex_rd<=id_rd.
//  - hazard = id_valid & ((ex_ld & ex_rd!=0 & match(ex_rd)) | (!MEM_FWD & mem_ld & mem_rd!=0 & match(mem_rd)));
//    match(r) = (uses_rs1 & r==id_rs1) | (uses_rs2 & r==id_rs2). x0 never hazards.
//  - Outputs are combinational (same cycle) from state and inputs:
//    flush_now = ex_br_taken | (state==FLUSH).
//    flush_now: ifid_flush=1, idex_flush=1, stall=0, pc_write=1, ifid_write=1.
//      Branch wins over a simultaneous load-use hazard: the stalled instruction is wrong-path.
//    else hazard: stall=1, pc_write=0, ifid_write=0, idex_flush=0. Held while the hazard persists.
//      Each stall cycle inserts one bubble, so the EX load moves on and the hazard clears.
//      Load-use latency: 1 stall cycle with MEM_FWD=1; 2 stall cycles with MEM_FWD=0.
//    else: stall=0, pc_write=1, ifid_write=1, flushes=0.
//  - FSM, 2-bit flush counter fcnt:
//    RUN: ex_br_taken & FLUSH_CYCLES>1 -> FLUSH, fcnt<=FLUSH_CYCLES-2.
//    FLUSH: fcnt==0 -> RUN, else fcnt<=fcnt-1.
//    ex_br_taken while in FLUSH reloads fcnt (restart penalty).
//    Net effect: idex_flush is high for exactly FLUSH_CYCLES cycles after the last taken branch.
//  - Counters: saturate at 2^CNT_W-1 (no wrap). cnt_clr has priority over increment in the same cycle.
//  - Reset mid-stall or mid-flush: outputs drop low immediately, FSM returns to RUN, tracked loads are discarded.
// TESTING
//  1. ld x5 in EX, add x6,x5,x7 in ID (MEM_FWD=1) -> stall=1, pc_write=0 for 1 cycle, then add issues; stall_cnt=1.
//  2. MEM_FWD=0, ld x5 then add x6,x5,x1 back-to-back -> stall=1 for 2 consecutive cycles; stall_cnt=2.
//  3. ld x0 followed by add x1,x0,x0, and ld x5 followed by addi x6,x2,1 (rs2 field=5) -> no stall.
//  4. ex_br_taken with a load-use hazard in the same cycle, FLUSH_CYCLES=2 -> stall=0, idex_flush=1 for 2 cycles, flush_cnt=2.
//  5. rst_n low during the 2nd flush cycle -> all outputs 0 asynchronously; after release state=RUN, counters=0.
//  6. CNT_W=4, hold hazard-generating stream 20 stall cycles -> stall_cnt=15 (saturated); cnt_clr pulse -> 0.

Source files
------------

// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit
//   Load-use hazard detection and branch flush sequencing for the 5-stage
//   RV64 pipeline, with saturating stall/flush cycle counters.
//
//   Parameters
//     MEM_FWD       1: MEM/WB forwarding present, only EX-stage loads hazard
//                   0: loads in MEM also hazard
//     FLUSH_CYCLES  IF/ID + ID/EX flush cycles per taken branch (1..3)
//     CNT_W         width of the saturating performance counters
//
//   Ports
//     clk, rst_n            clock, asynchronous active-low reset
//     id_valid/opcode/rs1/rs2/rd   instruction currently in ID
//     ex_br_taken           branch in EX resolved taken
//     cnt_clr               synchronous clear of both counters
//     stall                 bubble request to Control_Unit
//     pc_write, ifid_write  front-end write enables
//     ifid_flush, idex_flush  pipeline register clears
//     stall_cnt, flush_cnt  saturating cycle counters
module hazard_stall_unit #(
  parameter int MEM_FWD      = 1,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [6:0]       id_opcode,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic             ex_br_taken,
  input  logic             cnt_clr,
  output logic             stall,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic {RUN, FLUSH} state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic       CHK_MEM   = (MEM_FWD == 0);
  localparam logic       MULTI_FL  = (FLUSH_CYCLES > 1);
  // Cycles still to flush after the branch cycle, minus one.
  localparam logic [1:0] F_RELOAD  = MULTI_FL ? 2'(FLUSH_CYCLES - 2) : 2'd0;

  state_t     state, state_n;
  logic [1:0] fcnt, fcnt_n;
  logic       ex_ld, mem_ld;
  logic [4:0] ex_rd, mem_rd;
  logic       use1, use2, hazard, flush_now;
  logic       stall_i, flush_i;

  function automatic logic uses_rs1(input logic [6:0] op);
    return (op == 7'b0110011) || (op == 7'b0100011) || (op == 7'b1100011) ||
           (op == 7'b0000011) || (op == 7'b0010011);
  endfunction

  function automatic logic uses_rs2(input logic [6:0] op);
    return (op == 7'b0110011) || (op == 7'b0100011) || (op == 7'b1100011);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // Hazard detection against loads in EX (and MEM without MEM forwarding).
  // x0 destinations are excluded: they never carry data.
  always_comb begin
    use1   = uses_rs1(id_opcode);
    use2   = uses_rs2(id_opcode);
    hazard = 1'b0;
    if (id_valid) begin
      if (ex_ld && (ex_rd != 5'd0) &&
          ((use1 && (ex_rd == id_rs1)) || (use2 && (ex_rd == id_rs2))))
        hazard = 1'b1;
      if (CHK_MEM && mem_ld && (mem_rd != 5'd0) &&
          ((use1 && (mem_rd == id_rs1)) || (use2 && (mem_rd == id_rs2))))
        hazard = 1'b1;
    end
  end

  // Output decode and flush FSM next state. A taken branch beats a hazard:
  // the instruction that would stall is on the wrong path anyway.
  always_comb begin
    state_n   = state;
    fcnt_n    = fcnt;
    flush_now = ex_br_taken || (state == FLUSH);
    stall_i   = !flush_now && hazard;
    flush_i   = flush_now;

    stall      = rst_n && stall_i;
    pc_write   = rst_n && !stall_i;
    ifid_write = rst_n && !stall_i;
    ifid_flush = rst_n && flush_i;
    idex_flush = rst_n && flush_i;

    case (state)
      RUN: begin
        if (ex_br_taken && MULTI_FL) begin
          state_n = FLUSH;
          fcnt_n  = F_RELOAD;
        end
      end
      FLUSH: begin
        if (ex_br_taken)       fcnt_n  = F_RELOAD;
        else if (fcnt == 2'd0) state_n = RUN;
        else                   fcnt_n  = fcnt - 2'd1;
      end
      default: state_n = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      fcnt  <= 2'd0;
    end else begin
      state <= state_n;
      fcnt  <= fcnt_n;
    end
  end

  // Load tracking: a stalled or flushed ID instruction enters EX as a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_ld  <= 1'b0;
      ex_rd  <= 5'd0;
      mem_ld <= 1'b0;
      mem_rd <= 5'd0;
    end else begin
      mem_ld <= ex_ld;
      mem_rd <= ex_rd;
      if (stall_i || flush_i) begin
        ex_ld <= 1'b0;
      end else begin
        ex_ld <= id_valid && (id_opcode == OP_LOAD);
        ex_rd <= id_rd;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (cnt_clr) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_i) stall_cnt <= sat_inc(stall_cnt);
      if (flush_i) flush_cnt <= sat_inc(flush_cnt);
    end
  end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Testbench for hazard_stall_unit: three configurations driven in parallel
// with directed scenarios and random traffic, checked against a
// pipeline-occupancy reference model.
module tb_hazard_stall_unit;

  localparam logic [6:0] LD   = 7'b0000011;
  localparam logic [6:0] ADD  = 7'b0110011;
  localparam logic [6:0] ADDI = 7'b0010011;
  localparam logic [6:0] ST   = 7'b0100011;
  localparam logic [6:0] BEQ  = 7'b1100011;
  localparam logic [6:0] LUI  = 7'b0110111;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       id_valid = 1'b0;
  logic [6:0] id_opcode = 7'd0;
  logic [4:0] id_rs1 = 5'd0, id_rs2 = 5'd0, id_rd = 5'd0;
  logic       ex_br_taken = 1'b0;
  logic       cnt_clr = 1'b0;

  logic st[3], pw[3], iw[3], ifl[3], xfl[3];
  logic [15:0] sc0, fc0;
  logic [3:0]  sc1, fc1;
  logic [7:0]  sc2, fc2;
  logic [15:0] scnt[3], fcnt[3];

  assign scnt[0] = sc0;
  assign fcnt[0] = fc0;
  assign scnt[1] = {12'd0, sc1};
  assign fcnt[1] = {12'd0, fc1};
  assign scnt[2] = {8'd0, sc2};
  assign fcnt[2] = {8'd0, fc2};

  always #5 clk = ~clk;

  hazard_stall_unit #(.MEM_FWD(1), .FLUSH_CYCLES(1), .CNT_W(16)) u_d0 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .ex_br_taken(ex_br_taken),
    .cnt_clr(cnt_clr), .stall(st[0]), .pc_write(pw[0]), .ifid_write(iw[0]),
    .ifid_flush(ifl[0]), .idex_flush(xfl[0]), .stall_cnt(sc0), .flush_cnt(fc0));

  hazard_stall_unit #(.MEM_FWD(0), .FLUSH_CYCLES(2), .CNT_W(4)) u_d1 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .ex_br_taken(ex_br_taken),
    .cnt_clr(cnt_clr), .stall(st[1]), .pc_write(pw[1]), .ifid_write(iw[1]),
    .ifid_flush(ifl[1]), .idex_flush(xfl[1]), .stall_cnt(sc1), .flush_cnt(fc1));

  hazard_stall_unit #(.MEM_FWD(1), .FLUSH_CYCLES(3), .CNT_W(8)) u_d2 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .ex_br_taken(ex_br_taken),
    .cnt_clr(cnt_clr), .stall(st[2]), .pc_write(pw[2]), .ifid_write(iw[2]),
    .ifid_flush(ifl[2]), .idex_flush(xfl[2]), .stall_cnt(sc2), .flush_cnt(fc2));

  // Configuration of each instance as seen by the model.
  function automatic bit cfg_memfwd(int k);
    return (k != 1);
  endfunction
  function automatic int cfg_flush(int k);
    return k + 1;
  endfunction
  function automatic int cfg_max(int k);
    return (k == 0) ? 65535 : (k == 1) ? 15 : 255;
  endfunction

  // Reference model: what occupies EX and MEM, and how many flush cycles
  // are still owed after the current one.
  bit m_ex_ld[3], m_mem_ld[3];
  int m_ex_rd[3], m_mem_rd[3];
  int m_fleft[3];
  int m_scnt[3], m_fcnt[3];

  int nchk = 0;
  int nfail = 0;

  task automatic chk(input string tag, input int k, input logic [15:0] obs,
                     input logic [15:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s[d%0d] observed=%0d expected=%0d", tag, k, obs, exp);
    end
  endtask

  function automatic bit reads_rs1(logic [6:0] op);
    return op inside {ADD, ST, BEQ, LD, ADDI};
  endfunction
  function automatic bit reads_rs2(logic [6:0] op);
    return op inside {ADD, ST, BEQ};
  endfunction

  function automatic bit dep_on(int r);
    return (r != 0) && ((reads_rs1(id_opcode) && r == int'(id_rs1)) ||
                        (reads_rs2(id_opcode) && r == int'(id_rs2)));
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 3; k++) begin
      m_ex_ld[k] = 0; m_mem_ld[k] = 0; m_ex_rd[k] = 0; m_mem_rd[k] = 0;
      m_fleft[k] = 0; m_scnt[k] = 0; m_fcnt[k] = 0;
    end
  endtask

  task automatic step(input logic v, input logic [6:0] op, input logic [4:0] r1,
                      input logic [4:0] r2, input logic [4:0] rd,
                      input logic br, input logic clr);
    bit es[3], ef[3];
    id_valid = v; id_opcode = op; id_rs1 = r1; id_rs2 = r2; id_rd = rd;
    ex_br_taken = br; cnt_clr = clr;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      bit hz;
      hz = v && ((m_ex_ld[k] && dep_on(m_ex_rd[k])) ||
                 (!cfg_memfwd(k) && m_mem_ld[k] && dep_on(m_mem_rd[k])));
      ef[k] = br || (m_fleft[k] > 0);
      es[k] = !ef[k] && hz;
      chk("stall", k, 16'(st[k]), 16'(es[k]));
      chk("pc_write", k, 16'(pw[k]), 16'(!es[k]));
      chk("ifid_write", k, 16'(iw[k]), 16'(!es[k]));
      chk("ifid_flush", k, 16'(ifl[k]), 16'(ef[k]));
      chk("idex_flush", k, 16'(xfl[k]), 16'(ef[k]));
      chk("stall_cnt", k, scnt[k], 16'(m_scnt[k]));
      chk("flush_cnt", k, fcnt[k], 16'(m_fcnt[k]));
    end
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      m_mem_ld[k] = m_ex_ld[k];
      m_mem_rd[k] = m_ex_rd[k];
      if (es[k] || ef[k]) m_ex_ld[k] = 0;
      else begin
        m_ex_ld[k] = v && (op == LD);
        m_ex_rd[k] = int'(rd);
      end
      if (br) m_fleft[k] = cfg_flush(k) - 1;
      else if (m_fleft[k] > 0) m_fleft[k]--;
      if (clr) begin
        m_scnt[k] = 0; m_fcnt[k] = 0;
      end else begin
        if (es[k] && m_scnt[k] < cfg_max(k)) m_scnt[k]++;
        if (ef[k] && m_fcnt[k] < cfg_max(k)) m_fcnt[k]++;
      end
    end
    #1;
  endtask

  task automatic nop(input logic clr);
    step(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0, clr);
  endtask

  // Asserts reset mid-cycle with busy inputs, checks the forced-low outputs,
  // then releases it away from the clock edge with idle inputs.
  task automatic do_reset();
    id_valid = 1'b1; id_opcode = ADD; id_rs1 = 5'd5; id_rs2 = 5'd5;
    ex_br_taken = 1'b1;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("rst_stall", k, 16'(st[k]), 16'd0);
      chk("rst_pc_write", k, 16'(pw[k]), 16'd0);
      chk("rst_ifid_write", k, 16'(iw[k]), 16'd0);
      chk("rst_ifid_flush", k, 16'(ifl[k]), 16'd0);
      chk("rst_idex_flush", k, 16'(xfl[k]), 16'd0);
      chk("rst_stall_cnt", k, scnt[k], 16'd0);
      chk("rst_flush_cnt", k, fcnt[k], 16'd0);
    end
    model_clear();
    id_valid = 1'b0; ex_br_taken = 1'b0; cnt_clr = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [6:0] ops[6];
    ops = '{LD, ADD, ADDI, ST, BEQ, LUI};
    model_clear();
    #3;
    do_reset();

    // Load-use: ld x5 ; add x6,x5,x7 held in ID until it issues.
    step(1'b1, LD,  5'd1, 5'd0, 5'd5, 1'b0, 1'b0);
    step(1'b1, ADD, 5'd5, 5'd7, 5'd6, 1'b0, 1'b0);
    step(1'b1, ADD, 5'd5, 5'd7, 5'd6, 1'b0, 1'b0);
    step(1'b1, ADD, 5'd5, 5'd7, 5'd6, 1'b0, 1'b0);
    nop(1'b0);
    chk("t1_stall_cnt", 0, scnt[0], 16'd1);
    chk("t2_stall_cnt", 1, scnt[1], 16'd2);

    // x0 destination and unused rs2 field never stall.
    nop(1'b1);
    step(1'b1, LD,   5'd1, 5'd0, 5'd0, 1'b0, 1'b0);
    step(1'b1, ADD,  5'd0, 5'd0, 5'd1, 1'b0, 1'b0);
    step(1'b1, LD,   5'd1, 5'd0, 5'd5, 1'b0, 1'b0);
    step(1'b1, ADDI, 5'd2, 5'd5, 5'd6, 1'b0, 1'b0);
    nop(1'b0);
    chk("t3_stall_cnt", 0, scnt[0], 16'd0);
    chk("t3_stall_cnt", 1, scnt[1], 16'd0);

    // Branch coinciding with a load-use hazard.
    nop(1'b1);
    step(1'b1, LD,  5'd1, 5'd0, 5'd5, 1'b0, 1'b0);
    step(1'b1, ADD, 5'd5, 5'd1, 5'd6, 1'b1, 1'b0);
    nop(1'b0);
    nop(1'b0);
    nop(1'b0);
    chk("t4_flush_cnt", 0, fcnt[0], 16'd1);
    chk("t4_flush_cnt", 1, fcnt[1], 16'd2);
    chk("t4_flush_cnt", 2, fcnt[2], 16'd3);
    chk("t4_stall_cnt", 1, scnt[1], 16'd0);

    // Reset during the second flush cycle.
    nop(1'b1);
    step(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
    chk("t5_flush2", 1, 16'(xfl[1]), 16'd1);
    #2;
    do_reset();
    nop(1'b0);
    nop(1'b0);

    // Counter saturation and clear.
    for (int i = 0; i < 20; i++) begin
      step(1'b1, LD,  5'd1, 5'd0, 5'd5, 1'b0, 1'b0);
      step(1'b1, ADD, 5'd5, 5'd5, 5'd6, 1'b0, 1'b0);
      step(1'b1, ADD, 5'd5, 5'd5, 5'd6, 1'b0, 1'b0);
    end
    chk("t6_sat", 1, scnt[1], 16'd15);
    nop(1'b1);
    chk("t6_clr", 1, scnt[1], 16'd0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 9) != 0), ops[$urandom_range(0, 5)],
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
           5'($urandom_range(0, 7)), ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 49) == 0));
      if (i == 200) begin
        #2;
        do_reset();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
